// File: rtl/gcn_pkg.sv
// Shared definitions for the GCN aggregation/argmax stage: FSM state
// encoding, default parameter constants and the saturating adder.
package gcn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELF      = 3'd1,
    ST_EDGE_WAIT = 3'd2,
    ST_EDGE_FWD  = 3'd3,
    ST_EDGE_BWD  = 3'd4,
    ST_ARGMAX    = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam int DEF_NUM_NODES      = 6;
  localparam int DEF_NUM_CLASSES    = 3;
  localparam int DEF_MAX_EDGES      = 16;
  localparam int DEF_DOT_PROD_WIDTH = 16;
  localparam int DEF_ACC_WIDTH      = 20;
  localparam int DEF_SELF_LOOP      = 1;

  // Working width of the saturating adder; callers sign-extend into it
  // and truncate the result back to their accumulator width.
  localparam int SAT_W = 64;

  // Signed add that clamps to the range of an acc_width-bit signed value.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      acc_width
  );
    logic signed [SAT_W:0] one_s;
    logic signed [SAT_W:0] sum_s;
    logic signed [SAT_W:0] max_s;
    logic signed [SAT_W:0] min_s;
    one_s = {{SAT_W{1'b0}}, 1'b1};
    sum_s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    max_s = (one_s <<< (acc_width - 32'sd1)) - one_s;
    // Two's complement: -max-1 is the bitwise inverse of max.
    min_s = ~max_s;
    if (sum_s > max_s) begin
      sat_add = max_s[SAT_W-1:0];
    end else if (sum_s < min_s) begin
      sat_add = min_s[SAT_W-1:0];
    end else begin
      sat_add = sum_s[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/gcn_row_argmax.sv
// Combinational argmax over one accumulator row; ties go to the lowest
// class index because only a strictly greater value replaces the best.
module gcn_row_argmax
  import gcn_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int CLASS_BW    = $clog2(NUM_CLASSES)
) (
  input  logic [NUM_CLASSES*ACC_WIDTH-1:0] vals,
  output logic [CLASS_BW-1:0]              max_idx
);

  logic signed [ACC_WIDTH-1:0] best_s;
  logic signed [ACC_WIDTH-1:0] cand_s;
  logic [CLASS_BW-1:0]         idx_s;

  // Linear scan keeping the first maximum seen.
  always_comb begin
    best_s = $signed(vals[ACC_WIDTH-1:0]);
    cand_s = best_s;
    idx_s  = '0;
    for (int c = 1; c < NUM_CLASSES; c++) begin
      cand_s = $signed(vals[c*ACC_WIDTH +: ACC_WIDTH]);
      if (cand_s > best_s) begin
        best_s = cand_s;
        idx_s  = CLASS_BW'(c);
      end else begin
        best_s = best_s;
        idx_s  = idx_s;
      end
    end
  end

  assign max_idx = idx_s;

endmodule

// File: rtl/gcn_aggregate_argmax.sv
// GCN aggregation + classification: accumulates transformed node rows over
// a stream of COO edges (both directions, optional self-loops) with
// saturating arithmetic, then emits one argmax class index per node.
module gcn_aggregate_argmax
  import gcn_pkg::*;
#(
  parameter int NUM_NODES      = DEF_NUM_NODES,
  parameter int NUM_CLASSES    = DEF_NUM_CLASSES,
  parameter int MAX_EDGES      = DEF_MAX_EDGES,
  parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int SELF_LOOP      = DEF_SELF_LOOP,
  parameter int NODE_BW        = $clog2(NUM_NODES),
  parameter int CLASS_BW       = $clog2(NUM_CLASSES),
  parameter int EDGE_BW        = $clog2(MAX_EDGES + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [EDGE_BW-1:0]                    num_edges,
  input  logic                                  edge_valid,
  output logic                                  edge_ready,
  input  logic [NODE_BW-1:0]                    edge_src,
  input  logic [NODE_BW-1:0]                    edge_dst,
  output logic [NODE_BW-1:0]                    row_addr,
  input  logic [DOT_PROD_WIDTH*NUM_CLASSES-1:0] row_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [CLASS_BW*NUM_NODES-1:0]         class_out
);

  localparam logic [NODE_BW:0]   NODES_EXT = NUM_NODES[NODE_BW:0];
  localparam logic [NODE_BW-1:0] LAST_NODE = NODE_BW'(NUM_NODES - 32'sd1);
  localparam logic [NODE_BW-1:0] NODE_ONE  = {{(NODE_BW-1){1'b0}}, 1'b1};
  localparam logic [EDGE_BW-1:0] EDGE_MAX  = EDGE_BW'(MAX_EDGES);
  localparam logic [EDGE_BW-1:0] EDGE_ONE  = {{(EDGE_BW-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t next_state_s;

  logic [NODE_BW-1:0] node_cnt_r;
  logic [NODE_BW-1:0] src_r;
  logic [NODE_BW-1:0] dst_r;
  logic [EDGE_BW-1:0] num_edges_r;
  logic [EDGE_BW-1:0] edge_cnt_r;
  logic [EDGE_BW-1:0] num_edges_clamp_s;

  logic signed [ACC_WIDTH-1:0] acc_r [NUM_NODES][NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] sum_s [NUM_CLASSES];

  logic                 hs_s;
  logic                 oob_s;
  logic                 last_node_s;
  logic                 wait_last_s;
  logic                 proc_last_s;
  logic [NODE_BW-1:0]   row_addr_s;
  logic [NODE_BW-1:0]   add_node_s;
  logic                 add_en_s;
  logic                 busy_nxt_s;
  logic                 done_nxt_s;
  logic                 ready_nxt_s;

  logic                 busy_r;
  logic                 done_r;
  logic                 err_r;
  logic                 edge_ready_r;
  logic [CLASS_BW*NUM_NODES-1:0] class_out_r;

  logic [NUM_CLASSES*ACC_WIDTH-1:0] argmax_vals_s;
  logic [CLASS_BW-1:0]              argmax_idx_s;

  // Shared condition decode for the FSM and datapath.
  always_comb begin
    num_edges_clamp_s = (num_edges > EDGE_MAX) ? EDGE_MAX : num_edges;
    hs_s        = edge_valid & edge_ready_r;
    oob_s       = ({1'b0, edge_src} >= NODES_EXT) || ({1'b0, edge_dst} >= NODES_EXT);
    last_node_s = (node_cnt_r == LAST_NODE);
    // The edge being accepted right now is the last one of the run.
    wait_last_s = ((edge_cnt_r + EDGE_ONE) == num_edges_r);
    // The edge currently in FWD/BWD is the last one of the run.
    proc_last_s = (edge_cnt_r == num_edges_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!start) begin
          next_state_s = ST_IDLE;
        end else if (SELF_LOOP != 32'sd0) begin
          next_state_s = ST_SELF;
        end else if (num_edges_clamp_s == '0) begin
          next_state_s = ST_ARGMAX;
        end else begin
          next_state_s = ST_EDGE_WAIT;
        end
      end
      ST_SELF: begin
        if (!last_node_s) begin
          next_state_s = ST_SELF;
        end else if (num_edges_r == '0) begin
          next_state_s = ST_ARGMAX;
        end else begin
          next_state_s = ST_EDGE_WAIT;
        end
      end
      ST_EDGE_WAIT: begin
        if (!hs_s) begin
          next_state_s = ST_EDGE_WAIT;
        end else if (!oob_s) begin
          next_state_s = ST_EDGE_FWD;
        end else begin
          next_state_s = wait_last_s ? ST_ARGMAX : ST_EDGE_WAIT;
        end
      end
      ST_EDGE_FWD: begin
        if (src_r == dst_r) begin
          next_state_s = proc_last_s ? ST_ARGMAX : ST_EDGE_WAIT;
        end else begin
          next_state_s = ST_EDGE_BWD;
        end
      end
      ST_EDGE_BWD:  next_state_s = proc_last_s ? ST_ARGMAX : ST_EDGE_WAIT;
      ST_ARGMAX:    next_state_s = last_node_s ? ST_DONE : ST_ARGMAX;
      ST_DONE:      next_state_s = ST_IDLE;
      default:      next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: row read address, accumulate target, next flag values.
  always_comb begin
    row_addr_s = '0;
    add_node_s = '0;
    add_en_s   = 1'b0;
    case (state_r)
      ST_SELF: begin
        row_addr_s = node_cnt_r;
        add_node_s = node_cnt_r;
        add_en_s   = 1'b1;
      end
      ST_EDGE_FWD: begin
        row_addr_s = src_r;
        add_node_s = dst_r;
        add_en_s   = 1'b1;
      end
      ST_EDGE_BWD: begin
        row_addr_s = dst_r;
        add_node_s = src_r;
        add_en_s   = 1'b1;
      end
      default: begin
        row_addr_s = '0;
        add_node_s = '0;
        add_en_s   = 1'b0;
      end
    endcase
    busy_nxt_s  = (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
    done_nxt_s  = (next_state_s == ST_DONE);
    ready_nxt_s = (next_state_s == ST_EDGE_WAIT);
  end

  // Saturating sum of the target accumulator row and the sign-extended input row.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      sum_s[c] = ACC_WIDTH'(sat_add(
                   SAT_W'(acc_r[add_node_s][c]),
                   SAT_W'($signed(row_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH])),
                   ACC_WIDTH));
    end
  end

  // Accumulator array: cleared on reset and on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_r[n][c] <= '0;
        end
      end
    end else if ((state_r == ST_IDLE) && start) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_r[n][c] <= '0;
        end
      end
    end else if (add_en_s) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_r[add_node_s][c] <= sum_s[c];
      end
    end
  end

  // Present the row of the node currently being classified to the argmax.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      argmax_vals_s[c*ACC_WIDTH +: ACC_WIDTH] = acc_r[node_cnt_r][c];
    end
  end

  gcn_row_argmax #(
    .NUM_CLASSES (NUM_CLASSES),
    .ACC_WIDTH   (ACC_WIDTH),
    .CLASS_BW    (CLASS_BW)
  ) u_row_argmax (
    .vals    (argmax_vals_s),
    .max_idx (argmax_idx_s)
  );

  // Run bookkeeping: counters, latched edge, error flag and class results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      node_cnt_r  <= '0;
      src_r       <= '0;
      dst_r       <= '0;
      num_edges_r <= '0;
      edge_cnt_r  <= '0;
      err_r       <= 1'b0;
      class_out_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            num_edges_r <= num_edges_clamp_s;
            edge_cnt_r  <= '0;
            node_cnt_r  <= '0;
            err_r       <= 1'b0;
          end
        end
        ST_SELF: begin
          node_cnt_r <= last_node_s ? '0 : (node_cnt_r + NODE_ONE);
        end
        ST_EDGE_WAIT: begin
          if (hs_s) begin
            src_r      <= edge_src;
            dst_r      <= edge_dst;
            edge_cnt_r <= edge_cnt_r + EDGE_ONE;
            if (oob_s) begin
              err_r <= 1'b1;
            end
          end
        end
        ST_ARGMAX: begin
          class_out_r[node_cnt_r*CLASS_BW +: CLASS_BW] <= argmax_idx_s;
          node_cnt_r <= last_node_s ? '0 : (node_cnt_r + NODE_ONE);
        end
        default: begin
          node_cnt_r <= node_cnt_r;
        end
      endcase
    end
  end

  // Registered handshake/status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      edge_ready_r <= 1'b0;
    end else begin
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      edge_ready_r <= ready_nxt_s;
    end
  end

  assign edge_ready = edge_ready_r;
  assign row_addr   = row_addr_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign class_out  = class_out_r;

endmodule

// File: tb/tb_gcn_aggregate_argmax.sv
// Directed bench for gcn_aggregate_argmax. Two instances: u_dut0 has no
// self-loops and a 16-bit accumulator, u_dut1 has self-loops and a 20-bit
// accumulator. sel chooses which one the shared stimulus drives.
module tb_gcn_aggregate_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        sel;
  logic        edge_valid;
  logic [4:0]  num_edges;
  logic [2:0]  edge_src;
  logic [2:0]  edge_dst;

  logic        start0, start1;
  logic        ready0, ready1, busy0, busy1, done0, done1, err0, err1;
  logic [2:0]  ra0, ra1;
  logic [47:0] rd0, rd1;
  logic [11:0] cls0, cls1;

  logic        ready_o, busy_o, done_o, err_o;
  logic [2:0]  ra_o;
  logic [11:0] cls_o;

  int          checks;
  int          errors;
  int          rows [6][3];
  int          es [32];
  int          ed [32];
  logic [255:0] stall_mask;

  assign start0  = start & ~sel;
  assign start1  = start & sel;
  assign ready_o = sel ? ready1 : ready0;
  assign busy_o  = sel ? busy1  : busy0;
  assign done_o  = sel ? done1  : done0;
  assign err_o   = sel ? err1   : err0;
  assign ra_o    = sel ? ra1    : ra0;
  assign cls_o   = sel ? cls1   : cls0;

  // Row memory for dut0; addresses past the last node return a marker row.
  always_comb begin
    rd0 = '0;
    for (int c = 0; c < 3; c++) begin
      if (ra0 < 3'd6) rd0[c*16 +: 16] = 16'(rows[ra0][c]);
      else            rd0[c*16 +: 16] = (c == 1) ? 16'd100 : 16'd0;
    end
  end

  // Row memory for dut1.
  always_comb begin
    rd1 = '0;
    for (int c = 0; c < 3; c++) begin
      if (ra1 < 3'd6) rd1[c*16 +: 16] = 16'(rows[ra1][c]);
      else            rd1[c*16 +: 16] = (c == 1) ? 16'd100 : 16'd0;
    end
  end

  gcn_aggregate_argmax #(
    .NUM_NODES(6), .NUM_CLASSES(3), .MAX_EDGES(16),
    .DOT_PROD_WIDTH(16), .ACC_WIDTH(16), .SELF_LOOP(0)
  ) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .num_edges(num_edges),
    .edge_valid(edge_valid), .edge_ready(ready0),
    .edge_src(edge_src), .edge_dst(edge_dst),
    .row_addr(ra0), .row_data(rd0),
    .busy(busy0), .done(done0), .err(err0), .class_out(cls0)
  );

  gcn_aggregate_argmax #(
    .NUM_NODES(6), .NUM_CLASSES(3), .MAX_EDGES(16),
    .DOT_PROD_WIDTH(16), .ACC_WIDTH(20), .SELF_LOOP(1)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .num_edges(num_edges),
    .edge_valid(edge_valid), .edge_ready(ready1),
    .edge_src(edge_src), .edge_dst(edge_dst),
    .row_addr(ra1), .row_data(rd1),
    .busy(busy1), .done(done1), .err(err1), .class_out(cls1)
  );

  task automatic clear_rows();
    for (int i = 0; i < 6; i++)
      for (int c = 0; c < 3; c++) rows[i][c] = 0;
  endtask

  task automatic set_rows_ramp();
    for (int i = 0; i < 6; i++) begin
      rows[i][0] = i; rows[i][1] = 2 * i; rows[i][2] = 0;
    end
  endtask

  task automatic set_ring_edges();
    for (int i = 0; i < 6; i++) begin
      es[i] = i; ed[i] = (i + 1) % 6;
    end
  endtask

  // Runs one job on the selected DUT. Cycle 0 is the cycle start is high.
  task automatic run_graph(input logic dut_sel, input int ne, input int n_list,
                           input int restart_cyc, input int abort_cyc,
                           output int done_cyc, output int acc_edges,
                           output int ready_cycles, output logic busy_first,
                           output logic busy_done);
    int   cyc;
    int   ei;
    logic hs;
    logic running;
    sel = dut_sel; done_cyc = -1; ei = 0; ready_cycles = 0; hs = 1'b0;
    busy_first = 1'b0; busy_done = 1'b1; running = 1'b1;
    @(negedge clk);
    num_edges = 5'(ne); start = 1'b1; edge_valid = 1'b0; cyc = 0;
    while (running) begin
      @(negedge clk);
      cyc = cyc + 1;
      start = (cyc == restart_cyc);
      if (hs) ei = ei + 1;
      hs = 1'b0;
      if (cyc == 1) busy_first = busy_o;
      if (cyc == abort_cyc) begin
        running = 1'b0;
      end else if (done_o) begin
        done_cyc = cyc; busy_done = busy_o; running = 1'b0;
      end else if (cyc >= 200) begin
        running = 1'b0;
      end else begin
        edge_valid = (ei < n_list) && !stall_mask[cyc];
        if (ei < n_list) begin
          edge_src = 3'(es[ei]); edge_dst = 3'(ed[ei]);
        end
        if (ready_o) ready_cycles = ready_cycles + 1;
        hs = edge_valid && ready_o;
      end
    end
    edge_valid = 1'b0; start = 1'b0;
    acc_edges = ei;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, err0, ready0, ra0, cls0} !== 19'd0) begin
      errors++; $display("FAIL reset_dut0 got %h exp 0", {busy0, done0, err0, ready0, ra0, cls0});
    end
    checks++;
    if ({busy1, done1, err1, ready1, ra1, cls1} !== 19'd0) begin
      errors++; $display("FAIL reset_dut1 got %h exp 0", {busy1, done1, err1, ready1, ra1, cls1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int dc, ae, rc; logic bf, bd;
    set_rows_ramp(); set_ring_edges();
    run_graph(1'b0, 6, 6, -1, -1, dc, ae, rc, bf, bd);
    checks++; if (dc !== 25) begin errors++; $display("FAIL directed_done_cycle got %0d exp 25", dc); end
    checks++; if (cls_o !== 12'h555) begin errors++; $display("FAIL directed_class got %h exp 555", cls_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL directed_err got %b exp 0", err_o); end
    checks++; if (rc !== 6) begin errors++; $display("FAIL directed_ready_cycles got %0d exp 6", rc); end
    checks++; if ({bf, bd} !== 2'b10) begin errors++; $display("FAIL directed_busy got %b exp 10", {bf, bd}); end
  endtask

  task automatic test_self_loop();
    int dc, ae, rc; logic bf, bd;
    for (int i = 0; i < 6; i++) begin
      rows[i][0] = -1; rows[i][1] = -1; rows[i][2] = 7;
    end
    rows[3][0] = 5; rows[3][1] = -2; rows[3][2] = 5;
    run_graph(1'b1, 0, 0, -1, -1, dc, ae, rc, bf, bd);
    checks++; if (dc !== 13) begin errors++; $display("FAIL selfloop_done_cycle got %0d exp 13", dc); end
    checks++; if (cls_o !== 12'hA2A) begin errors++; $display("FAIL selfloop_class got %h exp a2a", cls_o); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL selfloop_ready_cycles got %0d exp 0", rc); end
  endtask

  task automatic test_saturation();
    int dc, ae, rc; logic bf, bd;
    clear_rows();
    rows[0][0] = 32767;
    rows[1][1] = 1;
    rows[2][0] = -32768; rows[2][1] = -1; rows[2][2] = -1;
    for (int i = 0; i < 4; i++) begin es[i] = 0; ed[i] = 1; end
    for (int i = 4; i < 6; i++) begin es[i] = 2; ed[i] = 3; end
    run_graph(1'b0, 6, 6, -1, -1, dc, ae, rc, bf, bd);
    checks++; if (dc !== 25) begin errors++; $display("FAIL sat_done_cycle got %0d exp 25", dc); end
    checks++; if (cls_o !== 12'h041) begin errors++; $display("FAIL sat_class got %h exp 041", cls_o); end
  endtask

  task automatic test_stall();
    int dc, ae, rc; logic bf, bd;
    clear_rows();
    rows[1][1] = 5; rows[2][0] = 3;
    es[0] = 2; ed[0] = 2; es[1] = 1; ed[1] = 2;
    stall_mask = '0; stall_mask[3] = 1'b1;
    run_graph(1'b0, 2, 2, -1, -1, dc, ae, rc, bf, bd);
    stall_mask = '0;
    checks++; if (dc !== 13) begin errors++; $display("FAIL stall_done_cycle got %0d exp 13", dc); end
    checks++; if (cls_o !== 12'h010) begin errors++; $display("FAIL stall_class got %h exp 010", cls_o); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL stall_ready_cycles got %0d exp 3", rc); end
    checks++; if (ae !== 2) begin errors++; $display("FAIL stall_accepted got %0d exp 2", ae); end
  endtask

  task automatic test_error();
    int dc, ae, rc; logic bf, bd;
    clear_rows();
    rows[2][2] = 4;
    es[0] = 7; ed[0] = 1; es[1] = 2; ed[1] = 2;
    run_graph(1'b0, 2, 2, -1, -1, dc, ae, rc, bf, bd);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL error_flag got %b exp 1", err_o); end
    checks++; if (dc !== 10) begin errors++; $display("FAIL error_done_cycle got %0d exp 10", dc); end
    checks++; if (cls_o !== 12'h020) begin errors++; $display("FAIL error_class got %h exp 020", cls_o); end
    checks++; if (ae !== 2) begin errors++; $display("FAIL error_accepted got %0d exp 2", ae); end
  endtask

  task automatic test_clamp();
    int dc, ae, rc; logic bf, bd;
    clear_rows();
    rows[0][0] = 1;
    for (int i = 0; i < 20; i++) begin es[i] = 0; ed[i] = 0; end
    run_graph(1'b0, 20, 20, -1, -1, dc, ae, rc, bf, bd);
    checks++; if (ae !== 16) begin errors++; $display("FAIL clamp_accepted got %0d exp 16", ae); end
    checks++; if (dc !== 39) begin errors++; $display("FAIL clamp_done_cycle got %0d exp 39", dc); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL clamp_err_cleared got %b exp 0", err_o); end
  endtask

  task automatic test_reset_mid_run();
    int dc, ae, rc; logic bf, bd;
    set_rows_ramp();
    for (int i = 0; i < 6; i++) begin es[i] = (i + 3) % 6; ed[i] = (i + 4) % 6; end
    // Run dut0 once so class_out is non-zero, then abort the next run in EDGE_FWD.
    run_graph(1'b0, 6, 6, -1, -1, dc, ae, rc, bf, bd);
    run_graph(1'b0, 6, 6, -1, 2, dc, ae, rc, bf, bd);
    checks++; if (ra_o !== 3'd3) begin errors++; $display("FAIL midrun_row_addr got %0d exp 3", ra_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, err0, ready0, ra0, cls0} !== 19'd0) begin
      errors++; $display("FAIL midrun_reset_outputs got %h exp 0", {busy0, done0, err0, ready0, ra0, cls0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_ring_edges();
    run_graph(1'b0, 6, 6, 5, -1, dc, ae, rc, bf, bd);
    checks++; if (dc !== 25) begin errors++; $display("FAIL restart_done_cycle got %0d exp 25", dc); end
    checks++; if (cls_o !== 12'h555) begin errors++; $display("FAIL restart_class got %h exp 555", cls_o); end
    checks++; if (ae !== 6) begin errors++; $display("FAIL restart_accepted got %0d exp 6", ae); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; edge_valid = 1'b0;
    num_edges = 5'd0; edge_src = 3'd0; edge_dst = 3'd0; stall_mask = '0;
    clear_rows();
    for (int i = 0; i < 32; i++) begin es[i] = 0; ed[i] = 0; end
    test_reset();
    test_directed();
    test_self_loop();
    test_saturation();
    test_stall();
    test_error();
    test_clamp();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
